// File: rtl/cim_pkg.sv
// cim_pkg: shared state encoding and arithmetic helpers for the bit-serial CIM macro
package cim_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, UPDATE} state_t;
  function automatic int psum_w(input int dw, input int ip, input int rows);
    return dw + ip + $clog2(rows) + 1;
  endfunction
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/cim_column.sv
// cim_column: one weight bank with bit-serial MAC, partial sum, ADC model and accumulator
module cim_column
  import cim_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int BANK_DEPTH = 128,
  parameter int IN_PREC    = 4,
  parameter int ADC_PREC   = 6,
  parameter int ADC_SHIFT  = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(BANK_DEPTH)-1:0] wr_addr,
  input  logic signed [DATA_WIDTH-1:0]  wr_data,
  input  logic                          start,
  input  logic                          step,
  input  logic                          update,
  input  logic                          clr,
  input  logic                          mode,
  input  logic [$clog2(IN_PREC)-1:0]    bit_idx,
  input  logic [$clog2(BANK_DEPTH)-1:0] base,
  input  logic [ROWS*IN_PREC-1:0]       act,
  output logic [ACC_WIDTH-1:0]          acc
);
  localparam int AW = $clog2(BANK_DEPTH);
  localparam int PW = psum_w(DATA_WIDTH, IN_PREC, ROWS);
  logic signed [DATA_WIDTH-1:0] mem [BANK_DEPTH];
  logic signed [DATA_WIDTH-1:0] w_a [ROWS];
  logic [IN_PREC-1:0] act_a [ROWS];
  logic signed [PW-1:0] psum, plane;
  logic signed [63:0] adc;
  logic [ACC_WIDTH-1:0] adc_ext;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign act_a[r] = act[r*IN_PREC +: IN_PREC];
    assign w_a[r]   = mem[base + AW'(r)];
  end
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  always_comb begin
    plane = '0;
    for (int r = 0; r < ROWS; r++) plane = act_a[r][bit_idx] ? plane + PW'(w_a[r]) : plane;
  end
  assign adc     = sat_signed(64'(psum >>> ADC_SHIFT), ADC_PREC);
  assign adc_ext = ACC_WIDTH'(adc);
  always_ff @(posedge clk) begin
    if (rst) begin
      psum <= '0;
      acc  <= '0;
    end else begin
      if (start) psum <= '0;
      else if (step) psum <= psum + (plane <<< bit_idx);
      if (clr) acc <= '0;
      else if (update) acc <= mode ? adc_ext : acc + adc_ext;
    end
  end
endmodule

// File: rtl/cim_macro_bs.sv
// cim_macro_bs: parametrised bit-serial compute-in-memory macro with per-column accumulators
module cim_macro_bs
  import cim_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int BANK_DEPTH = 128,
  parameter int IN_PREC    = 4,
  parameter int ADC_PREC   = 6,
  parameter int ADC_SHIFT  = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(COLS)-1:0]       wr_col,
  input  logic [$clog2(BANK_DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(BANK_DEPTH)-1:0] in_base,
  input  logic [ROWS*IN_PREC-1:0]       in_act,
  input  logic                          in_mode,
  input  logic                          acc_clr,
  output logic                          out_valid,
  input  logic [$clog2(COLS)-1:0]       rd_col,
  output logic [ACC_WIDTH-1:0]          rd_data
);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(BANK_DEPTH);
  localparam int BW = $clog2(IN_PREC);
  state_t state, state_nx;
  logic [BW-1:0] bit_cnt;
  logic [AW-1:0] base_q;
  logic [ROWS*IN_PREC-1:0] act_q;
  logic mode_q, idle, accept, wr_fire, clr, last;
  logic [ACC_WIDTH-1:0] acc [COLS];
  assign idle     = state == IDLE;
  assign wr_ready = idle;
  assign in_ready = idle && !rst;
  assign accept   = idle && in_valid;
  assign wr_fire  = idle && wr_valid;
  assign clr      = idle && acc_clr;
  assign last     = bit_cnt == BW'(IN_PREC - 1);
  assign rd_data  = acc[rd_col];
  always_comb
    state_nx = idle ? (in_valid ? COMPUTE : IDLE) : state == COMPUTE ? (last ? UPDATE : COMPUTE) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      base_q    <= '0;
      act_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= (state == COMPUTE && !last) ? bit_cnt + 1'b1 : '0;
      out_valid <= state == UPDATE;
      if (accept) begin
        base_q <= in_base;
        act_q  <= in_act;
        mode_q <= in_mode;
      end
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_col
    cim_column #(
      .DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .BANK_DEPTH(BANK_DEPTH), .IN_PREC(IN_PREC),
      .ADC_PREC(ADC_PREC), .ADC_SHIFT(ADC_SHIFT), .ACC_WIDTH(ACC_WIDTH)
    ) u_col (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_fire && wr_col == CW'(c)),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (accept),
      .step    (state == COMPUTE),
      .update  (state == UPDATE),
      .clr     (clr),
      .mode    (mode_q),
      .bit_idx (bit_cnt),
      .base    (base_q),
      .act     (act_q),
      .acc     (acc[c])
    );
  end
endmodule

// File: tb/tb_cim_macro_bs.sv
// tb_cim_macro_bs: directed self-checking bench for the bit-serial CIM macro
module tb_cim_macro_bs;
  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_valid = 1'b0, wr_ready;
  logic [2:0]  wr_col = '0;
  logic [6:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [6:0]  in_base = '0;
  logic [31:0] in_act = '0;
  logic        in_mode = 1'b0, acc_clr = 1'b0, out_valid;
  logic [2:0]  rd_col = '0;
  logic [31:0] rd_data;
  int total = 0, passed = 0, n, seen;

  cim_macro_bs dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col),
    .wr_addr(wr_addr), .wr_data(wr_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_act(in_act), .in_mode(in_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .rd_col(rd_col), .rd_data(rd_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rd(input int col, input logic [31:0] exp, input string tag);
    rd_col = 3'(col);
    #1;
    check(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic write_w(input int col, input int addr, input logic [7:0] data);
    wr_valid = 1'b1; wr_col = 3'(col); wr_addr = 7'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic start_op(input logic [6:0] base, input logic [31:0] act, input logic mode, input logic clr);
    in_base = base; in_act = act; in_mode = mode; acc_clr = clr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!out_valid && edges < 20);
  endtask

  initial begin
    @(posedge clk); #1;
    check("in_ready_in_rst", 64'(in_ready), 64'd0);
    check("out_valid_in_rst", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready_reset", 64'(in_ready), 64'd1);
    check("wr_ready_reset", 64'(wr_ready), 64'd1);
    for (int c = 0; c < 8; c++) rd(c, 32'd0, "acc_reset");
    for (int c = 0; c < 8; c++)
      for (int a = 0; a < 128; a++) write_w(c, a, 8'd0);

    for (int r = 0; r < 8; r++) write_w(0, r, 8'd16);
    start_op(7'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(n);
    check("latency_edges_after_accept", 64'(n), 64'd5);
    rd(0, 32'd7, "basic_col0");
    @(posedge clk); #1;
    check("out_valid_one_cycle", 64'(out_valid), 64'd0);
    start_op(7'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(n);
    rd(0, 32'd14, "accumulate_col0");

    for (int r = 0; r < 8; r++) begin
      write_w(1, r, 8'd127);
      write_w(2, r, 8'h80);
    end
    start_op(7'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(n);
    rd(1, 32'd31, "sat_pos");
    rd(2, 32'hFFFF_FFE0, "sat_neg");
    rd(0, 32'd21, "accumulate3_col0");

    for (int r = 124; r < 128; r++) write_w(3, r, 8'd40);
    for (int r = 0; r < 4; r++) write_w(3, r, 8'd20);
    for (int r = 4; r < 8; r++) write_w(3, r, 8'h9C);
    start_op(7'd124, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(n);
    rd(3, 32'd14, "wrap_col3");
    rd(0, 32'd24, "wrap_col0");
    start_op(7'd124, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(n);
    rd(3, 32'd14, "overwrite_col3");
    rd(0, 32'd3, "overwrite_col0");
    rd(2, 32'hFFFF_FFE2, "overwrite_col2");

    start_op(7'd0, 32'h7654_3210, 1'b0, 1'b1);
    wait_done(n);
    rd(0, 32'd1, "clr_accept_col0");
    rd(1, 32'd13, "clr_accept_col1");
    rd(2, 32'hFFFF_FFF2, "clr_accept_col2");
    rd(3, 32'hFFFF_FFF7, "clr_accept_floor_col3");

    start_op(7'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_col = 3'd0; wr_addr = 7'd0; wr_data = 8'd0; acc_clr = 1'b1;
    #1;
    check("wr_ready_busy", 64'(wr_ready), 64'd0);
    check("in_ready_busy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0; acc_clr = 1'b0;
    wait_done(n);
    rd(0, 32'd8, "busy_col0");
    rd(1, 32'd44, "busy_clr_ignored_col1");
    start_op(7'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(n);
    rd(0, 32'd15, "mem_unchanged_col0");
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    rd(0, 32'd0, "idle_clr_col0");
    rd(1, 32'd0, "idle_clr_col1");

    start_op(7'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_rst_mid", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    rd(1, 32'd0, "acc_after_rst");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_out_valid_after_rst", 64'(seen), 64'd0);
    start_op(7'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(n);
    rd(0, 32'd7, "retained_col0");
    rd(1, 32'd31, "retained_col1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
